// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter.
// The BCD word is consumed most significant digit first at one digit per clock
// (acc = acc*10 + digit). A start/busy/done handshake wraps the conversion, and
// any nibble above 9 is flagged on err with a zero result.
module bcd_to_bin_seq #(
  parameter int DIGITS = 4,
  parameter int BW     = 14
) (
  input  logic                  hz100,
  input  logic                  reset,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  busy,
  output logic                  done,
  output logic [BW-1:0]         bin_out,
  output logic                  err
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int AW    = BW + 4;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CONVERT = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;

  logic [4*DIGITS-1:0]   r_opnd;
  logic [AW-1:0]         r_acc;
  logic [IDX_W-1:0]      r_idx;
  logic                  r_err_i;
  logic [BW-1:0]         r_bin;
  logic                  r_err;

  logic                  w_accept;
  logic                  w_last;
  logic [3:0]            w_digit;
  logic                  w_digit_bad;
  logic [AW-1:0]         w_acc_nxt;
  logic                  w_err_nxt;

  // A new operand is taken only when no conversion is in flight.
  assign w_accept    = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_last      = (r_idx == '0);
  assign w_digit     = r_opnd[{r_idx, 2'b00} +: 4];
  assign w_digit_bad = (w_digit > 4'd9);
  // acc*10 built from two shifts; an invalid digit is still accumulated.
  assign w_acc_nxt   = (r_acc << 3) + (r_acc << 1) + AW'(w_digit);
  assign w_err_nxt   = r_err_i | w_digit_bad;

  // State register: reset aborts any conversion straight to IDLE.
  always_ff @(posedge hz100) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: CONVERT runs exactly DIGITS cycles, DONE lasts one.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (start) w_state_nxt = S_CONVERT;
      S_CONVERT: if (w_last) w_state_nxt = S_DONE;
      S_DONE:    w_state_nxt = start ? S_CONVERT : S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are pure state decodes, so start never reaches busy/done combinationally.
  always_comb begin
    busy    = (r_state == S_CONVERT);
    done    = (r_state == S_DONE);
    bin_out = r_bin;
    err     = r_err;
  end

  // Datapath: latch operand on accept, accumulate while converting, publish on the last digit.
  always_ff @(posedge hz100) begin
    if (reset) begin
      r_opnd  <= '0;
      r_acc   <= '0;
      r_idx   <= '0;
      r_err_i <= 1'b0;
      r_bin   <= '0;
      r_err   <= 1'b0;
    end else if (w_accept) begin
      r_opnd  <= bcd_in;
      r_acc   <= '0;
      r_idx   <= IDX_LAST;
      r_err_i <= 1'b0;
    end else if (r_state == S_CONVERT) begin
      r_acc   <= w_acc_nxt;
      r_err_i <= w_err_nxt;
      r_idx   <= r_idx - 1'b1;
      if (w_last) begin
        r_err <= w_err_nxt;
        r_bin <= w_err_nxt ? '0 : w_acc_nxt[BW-1:0];
      end
    end
  end

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Testbench for bcd_to_bin_seq: scenario tasks push expected results into a
// scoreboard queue, and a monitor pops and compares them on every done pulse.
module tb_bcd_to_bin_seq;

  localparam int DIGITS = 4;
  localparam int BW     = 14;

  logic          hz100 = 1'b0;
  logic          reset;
  logic          start;
  logic [15:0]   bcd_in;
  logic          busy;
  logic          done;
  logic [13:0]   bin_out;
  logic          err;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct packed {
    logic [13:0] bin;
    logic        err;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  bcd_to_bin_seq #(.DIGITS(DIGITS), .BW(BW)) dut (
    .hz100   (hz100),
    .reset   (reset),
    .start   (start),
    .bcd_in  (bcd_in),
    .busy    (busy),
    .done    (done),
    .bin_out (bin_out),
    .err     (err)
  );

  always #5 hz100 = ~hz100;

  always @(posedge hz100) cyc <= cyc + 1;

  // Reference: decimal value of the word, or zero with err if any nibble > 9.
  function automatic exp_t model(input logic [15:0] b);
    int   acc;
    int   d;
    bit   bad;
    exp_t e;
    acc = 0;
    bad = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      d = int'((b >> (4 * i)) & 16'h000F);
      if (d > 9) bad = 1'b1;
      acc = acc * 10 + d;
    end
    e.err = bad;
    e.bin = bad ? 14'd0 : acc[13:0];
    return e;
  endfunction

  // Scoreboard monitor: every done pulse must match the oldest expected result.
  always @(negedge hz100) begin
    if (!reset && done) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done bin_out=%0d err=%0b (no result expected)", bin_out, err);
      end else begin
        mon_e = sb.pop_front();
        if (bin_out !== mon_e.bin || err !== mon_e.err) begin
          errors++;
          $display("FAIL result got bin_out=%0d err=%0b expected bin_out=%0d err=%0b",
                   bin_out, err, mon_e.bin, mon_e.err);
        end
      end
    end
  end

  // Drive a one-cycle start with value v; returns at the first negedge after acceptance.
  task automatic start_pulse(input logic [15:0] v);
    start  = 1'b1;
    bcd_in = v;
    sb.push_back(model(v));
    @(negedge hz100);
    start  = 1'b0;
    bcd_in = 16'($urandom);
  endtask

  // Wait (bounded) for done, counting busy cycles seen on the way.
  task automatic wait_done(output int nb, output bit ok);
    nb = 0;
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      if (busy) nb++;
      @(negedge hz100);
    end
  endtask

  task automatic run_one(input logic [15:0] v, input string name);
    int   nb;
    bit   ok;
    exp_t e;
    e = model(v);
    start_pulse(v);
    wait_done(nb, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s_timeout done never seen, required within 20 cycles", name);
    end
    checks++;
    if (nb !== 4) begin
      errors++;
      $display("FAIL %s_busy_cycles got %0d required 4", name, nb);
    end
    @(negedge hz100);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_after_done got busy=%0b done=%0b required 0 0", name, busy, done);
    end
    checks++;
    if (bin_out !== e.bin || err !== e.err) begin
      errors++;
      $display("FAIL %s_hold got bin_out=%0d err=%0b required %0d %0b", name, bin_out, err, e.bin, e.err);
    end
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    start  = 1'b1;
    bcd_in = 16'h9999;
    repeat (2) @(negedge hz100);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b required 0", busy); end
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b required 0", done); end
    checks++;
    if (bin_out !== 14'd0) begin errors++; $display("FAIL reset_bin_out got %0d required 0", bin_out); end
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %0b required 0", err); end
    start = 1'b0;
    reset = 1'b0;
    @(negedge hz100);
  endtask

  task automatic test_basic();
    run_one(16'h9999, "conv_9999");
    run_one(16'h0000, "conv_0000");
    run_one(16'h1234, "conv_1234");
  endtask

  task automatic test_error();
    run_one(16'h12A4, "err_12A4");
    run_one(16'h0042, "after_err_0042");
  endtask

  task automatic test_ignore_start();
    int nb;
    bit ok;
    start_pulse(16'h0500);          // busy cycle 1
    @(negedge hz100);               // busy cycle 2
    start  = 1'b1;
    bcd_in = 16'h9999;
    @(negedge hz100);
    start  = 1'b0;
    wait_done(nb, ok);
    checks++;
    if (!ok || nb !== 2) begin
      errors++;
      $display("FAIL ignore_timing got ok=%0b busy_left=%0d required 1 2", ok, nb);
    end
    repeat (8) @(negedge hz100);
    checks++;
    if (sb.size() != 0 || bin_out !== 14'h01F4) begin
      errors++;
      $display("FAIL ignore_result got bin_out=%0d pending=%0d required 500 0", bin_out, sb.size());
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    start_pulse(16'h9999);          // busy cycle 1
    @(negedge hz100);               // busy cycle 2
    reset = 1'b1;
    @(negedge hz100);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || bin_out !== 14'd0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid got busy=%0b done=%0b bin_out=%0d err=%0b required all 0",
               busy, done, bin_out, err);
    end
    sb.delete();
    reset = 1'b0;
    seen  = 1'b0;
    repeat (10) begin
      @(negedge hz100);
      if (done) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL reset_mid_no_done got done pulse required none");
    end
  endtask

  task automatic test_back_to_back();
    int nb;
    bit ok1;
    bit ok2;
    int t1;
    int t2;
    start  = 1'b1;
    bcd_in = 16'h0001;
    sb.push_back(model(16'h0001));
    sb.push_back(model(16'h0010));
    @(negedge hz100);
    bcd_in = 16'h0010;
    wait_done(nb, ok1);
    t1 = cyc;
    @(negedge hz100);
    wait_done(nb, ok2);
    t2 = cyc;
    start = 1'b0;
    checks++;
    if (!ok1 || !ok2) begin
      errors++;
      $display("FAIL b2b_timeout got ok1=%0b ok2=%0b required 1 1", ok1, ok2);
    end
    checks++;
    if (t2 - t1 != 5) begin
      errors++;
      $display("FAIL b2b_interval got %0d required 5", t2 - t1);
    end
    checks++;
    if (nb !== 4) begin
      errors++;
      $display("FAIL b2b_busy_cycles got %0d required 4", nb);
    end
    repeat (3) @(negedge hz100);
    checks++;
    if (bin_out !== 14'd10 || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_final got bin_out=%0d busy=%0b required 10 0", bin_out, busy);
    end
  endtask

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    bcd_in = 16'h0000;
    @(negedge hz100);
    test_reset();
    test_basic();
    test_error();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    repeat (2) @(negedge hz100);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
